pacman_move: RTL and testbench

PACMAN_MOVE -- requirements
Module: pacman_move

---
 rtl/pacman_pkg.sv | 21 ++
 rtl/pacman_move_decide.sv | 113 +++++++++++
 rtl/pacman_move.sv | 124 ++++++++++++
 tb/tb_pacman_move.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared types and maze dimensions for the Pac-Man movement engine.
package pacman_pkg;

  localparam int MAZE_W = 22;
  localparam int MAZE_H = 32;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECIDE = 2'd2,
    UPDATE = 2'd3
  } state_t;

endpackage

// File: rtl/pacman_move_decide.sv
// Combinational move decision: turn into pending direction, continue, or stop.
// Build option: PACMAN_TUNNEL_EN wraps horizontally across the side edges.
module move_decide import pacman_pkg::*; #(
  parameter int DATA_WIDTH = MAZE_W,
  parameter int ADDR_WIDTH = $clog2(MAZE_H)
) (
  input  logic [DATA_WIDTH-1:0] row_cur,
  input  logic [DATA_WIDTH-1:0] row_up,
  input  logic [DATA_WIDTH-1:0] row_down,
  input  logic [4:0]            pos_x,
  input  logic [ADDR_WIDTH-1:0] pos_y,
  input  dir_t                  cur_dir,
  input  logic                  pend_valid,
  input  dir_t                  pend_dir,
  output logic [4:0]            next_x,
  output logic [ADDR_WIDTH-1:0] next_y,
  output dir_t                  next_dir,
  output logic                  moving,
  output logic                  pend_taken
);

  localparam logic [4:0]            X_MAX = 5'(DATA_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] Y_ONE = ADDR_WIDTH'(1'b1);

  logic                  in_range_s;
  logic                  pend_open_s;
  logic                  cur_open_s;
  logic [4:0]            pend_x_s;
  logic [4:0]            cur_x_s;
  logic [ADDR_WIDTH-1:0] pend_y_s;
  logic [ADDR_WIDTH-1:0] cur_y_s;

  assign in_range_s = (pos_x <= X_MAX);

  // Target cell of one step in direction d and whether it is open; rows wrap
  // naturally through the address width, columns only when tunnels exist.
  function automatic logic probe(input dir_t d, output logic [4:0] tx,
                                 output logic [ADDR_WIDTH-1:0] ty);
    tx    = pos_x;
    ty    = pos_y;
    probe = 1'b0;
    case (d)
      UP: begin
        ty    = pos_y - Y_ONE;
        probe = in_range_s & row_up[pos_x];
      end
      DOWN: begin
        ty    = pos_y + Y_ONE;
        probe = in_range_s & row_down[pos_x];
      end
      LEFT: begin
        if (pos_x == 5'd0) begin
`ifdef PACMAN_TUNNEL_EN
          tx    = X_MAX;
          probe = row_cur[X_MAX];
`else
          probe = 1'b0;
`endif
        end else if (in_range_s) begin
          tx    = pos_x - 5'd1;
          probe = row_cur[pos_x - 5'd1];
        end else begin
          probe = 1'b0;
        end
      end
      RIGHT: begin
        if (pos_x == X_MAX) begin
`ifdef PACMAN_TUNNEL_EN
          tx    = 5'd0;
          probe = row_cur[5'd0];
`else
          probe = 1'b0;
`endif
        end else if (pos_x < X_MAX) begin
          tx    = pos_x + 5'd1;
          probe = row_cur[pos_x + 5'd1];
        end else begin
          probe = 1'b0;
        end
      end
      default: probe = 1'b0;
    endcase
  endfunction

  // A pending request wins when its cell is open; otherwise keep heading.
  always_comb begin
    pend_x_s    = pos_x;
    pend_y_s    = pos_y;
    cur_x_s     = pos_x;
    cur_y_s     = pos_y;
    pend_open_s = probe(pend_dir, pend_x_s, pend_y_s);
    cur_open_s  = probe(cur_dir, cur_x_s, cur_y_s);
    next_x      = pos_x;
    next_y      = pos_y;
    next_dir    = cur_dir;
    moving      = 1'b0;
    pend_taken  = 1'b0;
    if (pend_valid && pend_open_s) begin
      next_x     = pend_x_s;
      next_y     = pend_y_s;
      next_dir   = pend_dir;
      moving     = 1'b1;
      pend_taken = 1'b1;
    end else if (cur_open_s) begin
      next_x = cur_x_s;
      next_y = cur_y_s;
      moving = 1'b1;
    end else begin
      moving = 1'b0;
    end
  end

endmodule

// File: rtl/pacman_move.sv
// Pac-Man movement engine: each accepted tick fetches the surrounding maze rows,
// decides the step and updates the position. Build option: PACMAN_TUNNEL_EN.
module pacman_move import pacman_pkg::*; #(
  parameter int DATA_WIDTH = MAZE_W,
  parameter int ADDR_WIDTH = $clog2(MAZE_H),
  parameter int NUM_READ   = 4,
  parameter int START_X    = 10,
  parameter int START_Y    = 23
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 tick,
  input  logic [1:0]                           dir_req,
  input  logic                                 dir_req_valid,
  output logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  r_addr,
  input  logic [NUM_READ-1:0][DATA_WIDTH-1:0]  r_data,
  output logic [4:0]                           pos_x,
  output logic [ADDR_WIDTH-1:0]                pos_y,
  output logic [1:0]                           cur_dir,
  output logic                                 moving,
  output logic                                 busy,
  output logic                                 move_done
);

  localparam logic [ADDR_WIDTH-1:0] Y_ONE = ADDR_WIDTH'(1'b1);

  state_t                state_r;
  dir_t                  dir_r;
  logic                  pend_valid_r;
  dir_t                  pend_dir_r;
  logic [4:0]            next_x_s;
  logic [ADDR_WIDTH-1:0] next_y_s;
  dir_t                  next_dir_s;
  logic                  moving_s;
  logic                  pend_taken_s;
  logic                  unused_s;

  assign cur_dir = dir_r;

  // Extra read ports repeat the current row and carry no new information.
  always_comb begin
    unused_s = 1'b0;
    for (int i = 3; i < NUM_READ; i++) begin
      unused_s = unused_s ^ (^r_data[i]);
    end
  end

  move_decide #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_decide (
    .row_cur    (r_data[0]),
    .row_up     (r_data[1]),
    .row_down   (r_data[2]),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .cur_dir    (dir_r),
    .pend_valid (pend_valid_r),
    .pend_dir   (pend_dir_r),
    .next_x     (next_x_s),
    .next_y     (next_y_s),
    .next_dir   (next_dir_s),
    .moving     (moving_s),
    .pend_taken (pend_taken_s)
  );

  // Movement FSM; row addresses are captured on entry to FETCH so they are
  // stable through FETCH and DECIDE, and results appear with move_done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      pos_x        <= 5'(START_X);
      pos_y        <= ADDR_WIDTH'(START_Y);
      dir_r        <= LEFT;
      moving       <= 1'b0;
      busy         <= 1'b0;
      move_done    <= 1'b0;
      pend_valid_r <= 1'b0;
      pend_dir_r   <= UP;
      r_addr       <= '0;
    end else begin
      if (dir_req_valid) begin
        pend_valid_r <= 1'b1;
        pend_dir_r   <= dir_t'(dir_req);
      end else if (state_r == DECIDE && pend_taken_s) begin
        pend_valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (tick) begin
            state_r   <= FETCH;
            busy      <= 1'b1;
            r_addr[0] <= pos_y;
            r_addr[1] <= pos_y - Y_ONE;
            r_addr[2] <= pos_y + Y_ONE;
            for (int i = 3; i < NUM_READ; i++) begin
              r_addr[i] <= pos_y;
            end
          end
        end
        FETCH: state_r <= DECIDE;
        DECIDE: begin
          pos_x     <= next_x_s;
          pos_y     <= next_y_s;
          dir_r     <= next_dir_s;
          moving    <= moving_s;
          move_done <= 1'b1;
          state_r   <= UPDATE;
        end
        UPDATE: begin
          move_done <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          move_done <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pacman_move.sv
// Directed bench for pacman_move with a behavioural maze/step model checked every cycle.
module tb_pacman_move;

  localparam int W = 22;
  localparam int H = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              tick;
  logic [1:0]        dir_req;
  logic              dir_req_valid;
  logic [3:0][4:0]   r_addr;
  logic [3:0][21:0]  r_data;
  logic [4:0]        pos_x;
  logic [4:0]        pos_y;
  logic [1:0]        cur_dir;
  logic              moving;
  logic              busy;
  logic              move_done;

  logic [21:0] rom [H];

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  // Model state
  int m_x = 10, m_y = 23, m_dir = 2, m_pd = 0, m_left = 0;
  bit m_pv = 1'b0, m_mov = 1'b0;
  int d_x, d_y, d_dir, px, py, cx, cy;
  bit d_mov, d_taken, p_ok, c_ok;

  pacman_move dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .dir_req       (dir_req),
    .dir_req_valid (dir_req_valid),
    .r_addr        (r_addr),
    .r_data        (r_data),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .cur_dir       (cur_dir),
    .moving        (moving),
    .busy          (busy),
    .move_done     (move_done)
  );

  always #5 clk = ~clk;

  always_comb begin
    r_data = '0;
    for (int i = 0; i < 4; i++) r_data[i] = rom[r_addr[i]];
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One step in direction d on the torus-like maze; columns past the edge are
  // walls unless tunnels exist.
  function automatic bit probe_dir(input int d, input int x, input int y,
                                   output int nx, output int ny);
    nx = x;
    ny = y;
    case (d)
      0:       ny = (y + H - 1) % H;
      1:       ny = (y + 1) % H;
      2:       nx = x - 1;
      default: nx = x + 1;
    endcase
    if (nx < 0 || nx >= W) begin
`ifdef PACMAN_TUNNEL_EN
      nx = (nx < 0) ? W - 1 : 0;
`else
      return 1'b0;
`endif
    end
    return rom[ny][nx];
  endfunction

  always_comb begin
    px = 0; py = 0; cx = 0; cy = 0;
    d_x = m_x; d_y = m_y; d_dir = m_dir; d_mov = 1'b0; d_taken = 1'b0;
    p_ok = probe_dir(m_pd, m_x, m_y, px, py);
    c_ok = probe_dir(m_dir, m_x, m_y, cx, cy);
    if (m_pv && p_ok) begin
      d_x = px; d_y = py; d_dir = m_pd; d_mov = 1'b1; d_taken = 1'b1;
    end else if (c_ok) begin
      d_x = cx; d_y = cy; d_mov = 1'b1;
    end
  end

  // m_left counts the cycles of a move still to show: 3 fetch, 2 decide, 1 done.
  always @(posedge clk) begin
    if (reset) begin
      m_x <= 10; m_y <= 23; m_dir <= 2; m_mov <= 1'b0;
      m_pv <= 1'b0; m_pd <= 0; m_left <= 0;
    end else begin
      if (m_left == 0) begin
        if (tick) m_left <= 3;
      end else begin
        m_left <= m_left - 1;
      end
      if (m_left == 2) begin
        m_x <= d_x; m_y <= d_y; m_dir <= d_dir; m_mov <= d_mov;
        if (d_taken) m_pv <= 1'b0;
      end
      if (dir_req_valid) begin
        m_pv <= 1'b1;
        m_pd <= int'(dir_req);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("busy", busy, (m_left != 0) ? 1 : 0);
      chk("move_done", move_done, (m_left == 1) ? 1 : 0);
      chk("pos_x", pos_x, m_x);
      chk("pos_y", pos_y, m_y);
      chk("cur_dir", cur_dir, m_dir);
      chk("moving", moving, m_mov ? 1 : 0);
      if (m_left == 3 || m_left == 2) begin
        chk("r_addr0", r_addr[0], m_y);
        chk("r_addr1", r_addr[1], (m_y + H - 1) % H);
        chk("r_addr2", r_addr[2], (m_y + 1) % H);
        chk("r_addr3", r_addr[3], m_y);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic req(input logic [1:0] d);
    dir_req = d; dir_req_valid = 1'b1;
    cyc();
    dir_req_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (move_done !== 1'b1 && n < 8) begin
      cyc();
      n++;
    end
    chk("done_seen", move_done, 1);
  endtask

  task automatic step_move();
    int n;
    do_tick();
    wait_done(n);
  endtask

  task automatic clear_rom();
    for (int r = 0; r < H; r++) rom[r] = '0;
  endtask

  initial begin
    int n, cnt;
    reset = 1'b1; tick = 1'b1; dir_req = 2'd0; dir_req_valid = 1'b0;
    clear_rom();
    rom[23] = 22'h3FFFFF;
    rom[22] = 22'h000200;
    cyc(); cyc();
    reset = 1'b0; tick = 1'b0;
    started = 1'b1;
    chk("rst_x", pos_x, 10); chk("rst_y", pos_y, 23); chk("rst_dir", cur_dir, 2);
    chk("rst_mov", moving, 0); chk("rst_busy", busy, 0); chk("rst_done", move_done, 0);
    chk("rst_addr1", r_addr[1], 0); chk("rst_addr2", r_addr[2], 0);

    // Plain left move, done three cycles after the tick
    do_tick(); wait_done(n);
    chk("lat", n, 2); chk("left_x", pos_x, 9); chk("left_y", pos_y, 23);
    chk("left_mov", moving, 1);
    cyc();

    // Pending up blocked, continue left; then pending taken
    do_reset();
    req(2'd0);
    step_move();
    chk("blk_x", pos_x, 9); chk("blk_y", pos_y, 23); chk("blk_dir", cur_dir, 2);
    cyc();
    step_move();
    chk("turn_x", pos_x, 9); chk("turn_y", pos_y, 22); chk("turn_dir", cur_dir, 0);
    cyc();

    // Boxed in: stay put, still completes
    rom[21] = '0; rom[23] = '0;
    step_move();
    chk("box_x", pos_x, 9); chk("box_y", pos_y, 22); chk("box_mov", moving, 0);
    cyc();

    // Horizontal edge
    do_reset();
    clear_rom();
    rom[23] = 22'h2007FF;
    for (int i = 0; i < 10; i++) begin step_move(); cyc(); end
    chk("edge_start_x", pos_x, 0);
    step_move();
`ifdef PACMAN_TUNNEL_EN
    chk("edge_left_x", pos_x, 21); chk("edge_left_mov", moving, 1);
`else
    chk("edge_left_x", pos_x, 0); chk("edge_left_mov", moving, 0);
`endif
    cyc();
    req(2'd3);
    step_move();
`ifdef PACMAN_TUNNEL_EN
    chk("edge_right_x", pos_x, 0);
`else
    chk("edge_right_x", pos_x, 1);
`endif
    chk("edge_right_dir", cur_dir, 3);
    cyc();

    // Second tick during FETCH is ignored
    do_reset();
    do_tick();
    tick = 1'b1; cyc(); tick = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (move_done === 1'b1) cnt++;
      cyc();
    end
    chk("one_done", cnt, 1); chk("dbl_x", pos_x, 9);

    // Reset during DECIDE aborts the move
    do_tick(); cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("abort_x", pos_x, 10); chk("abort_y", pos_y, 23); chk("abort_busy", busy, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (move_done === 1'b1) cnt++;
      cyc();
    end
    chk("abort_no_done", cnt, 0);

    // Vertical wrap through row 0
    do_reset();
    clear_rom();
    for (int r = 0; r <= 23; r++) rom[r] = 22'h000400;
    rom[31] = 22'h000400;
    req(2'd0);
    for (int i = 0; i < 23; i++) begin step_move(); cyc(); end
    chk("top_y", pos_y, 0);
    do_tick();
    chk("fetch_a1", r_addr[1], 31); chk("fetch_a2", r_addr[2], 1);
    cyc();
    chk("dec_a1", r_addr[1], 31); chk("dec_a2", r_addr[2], 1);
    cyc();
    chk("wrap_y", pos_y, 31); chk("wrap_done", move_done, 1);
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
